data_memory_arbiter: RTL and testbench

//  Shares the single-port SPRAM data memory between two requesters: port 0 (CPU load/store) and port 1 (UART host/debug).

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_rr_pick.sv | 34 +++
 rtl/data_memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding,
// requester port ids, data word width and the address range helper.
package dmem_arb_pkg;

    localparam int DMEM_WORD_W = 32;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2
    } arb_state_t;

    // A word address is serviceable only if it falls inside the implemented words;
    // the compare uses all 32 bits so aliases above the array are rejected.
    function automatic logic addr_in_range(input logic [DMEM_WORD_W-1:0] addr,
                                           input int unsigned            words);
        return addr < words;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker. Default: round-robin against the last granted port.
// With DMEM_ARB_HOST_PRIORITY_EN defined: the host port always wins a tie.
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       valid
);

`ifdef DMEM_ARB_HOST_PRIORITY_EN
    // The last-grant pointer has no role under fixed priority.
    logic unused_ptr;
    assign unused_ptr = ptr;

    // Fixed priority: host first, CPU only when the host is quiet.
    always_comb begin
        valid  = |req;
        winner = req[PORT_HOST] ? PORT_HOST : PORT_CPU;
    end
`else
    // Round-robin: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        valid = |req;
        if (req[PORT_CPU] && req[PORT_HOST]) begin
            winner = ~ptr;
        end else begin
            winner = req[PORT_HOST];
        end
    end
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the
// UART host/debug bridge (port 1). One registered word command per grant,
// read data returned two cycles after the grant with a one-cycle valid pulse.
// Optional macro DMEM_ARB_HOST_PRIORITY_EN selects fixed host priority.
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WORDS = 16384
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [DMEM_WORD_W-1:0] m0_addr,
    input  logic [DMEM_WORD_W-1:0] m0_wdata,
    output logic                   m0_gnt,
    output logic                   m0_err,
    output logic                   m0_rvalid,
    output logic [DMEM_WORD_W-1:0] m0_rdata,

    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [DMEM_WORD_W-1:0] m1_addr,
    input  logic [DMEM_WORD_W-1:0] m1_wdata,
    output logic                   m1_gnt,
    output logic                   m1_err,
    output logic                   m1_rvalid,
    output logic [DMEM_WORD_W-1:0] m1_rdata,

    output logic [DMEM_WORD_W-1:0] mem_addr,
    output logic [DMEM_WORD_W-1:0] mem_write_data,
    output logic                   mem_memwrite,
    output logic                   mem_memread,
    input  logic [DMEM_WORD_W-1:0] mem_read_data
);

    arb_state_t             state_reg;
    logic                   ptr_reg;
    logic                   winner_reg;
    logic [1:0]             gnt_reg;
    logic [1:0]             err_reg;
    logic [1:0]             rvalid_reg;
    logic [DMEM_WORD_W-1:0] rdata_reg [2];
    logic [DMEM_WORD_W-1:0] mem_addr_reg;
    logic [DMEM_WORD_W-1:0] mem_wdata_reg;
    logic                   memwrite_reg;
    logic                   memread_reg;

    logic                   pick_winner;
    logic                   pick_valid;
    logic                   sel_we;
    logic [DMEM_WORD_W-1:0] sel_addr;
    logic [DMEM_WORD_W-1:0] sel_wdata;
    logic                   sel_in_range;

    dmem_rr_pick u_pick (
        .req    ({m1_req, m0_req}),
        .ptr    (ptr_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Route the winning requester's command fields toward the command registers.
    always_comb begin
        sel_we       = pick_winner ? m1_we    : m0_we;
        sel_addr     = pick_winner ? m1_addr  : m0_addr;
        sel_wdata    = pick_winner ? m1_wdata : m0_wdata;
        sel_in_range = addr_in_range(sel_addr, ADDR_WORDS);
    end

    // Arbitration FSM: grant in IDLE, one command cycle in ISSUE, capture in RDATA.
    // Pulses default low every cycle so they last exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= PORT_HOST;
            winner_reg    <= PORT_CPU;
            gnt_reg       <= '0;
            err_reg       <= '0;
            rvalid_reg    <= '0;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            memwrite_reg  <= 1'b0;
            memread_reg   <= 1'b0;
        end else begin
            gnt_reg      <= '0;
            err_reg      <= '0;
            rvalid_reg   <= '0;
            memwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg            <= ST_ISSUE;
                        winner_reg           <= pick_winner;
                        ptr_reg              <= pick_winner;
                        gnt_reg[pick_winner] <= 1'b1;
                        if (sel_in_range) begin
                            mem_addr_reg  <= sel_addr;
                            mem_wdata_reg <= sel_wdata;
                            memwrite_reg  <= sel_we;
                            memread_reg   <= ~sel_we;
                        end else begin
                            err_reg[pick_winner] <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Only an accepted read needs the data-return cycle.
                    state_reg <= memread_reg ? ST_RDATA : ST_IDLE;
                end
                ST_RDATA: begin
                    rdata_reg[winner_reg]  <= mem_read_data;
                    rvalid_reg[winner_reg] <= 1'b1;
                    state_reg              <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_gnt         = gnt_reg[0];
    assign m0_err         = err_reg[0];
    assign m0_rvalid      = rvalid_reg[0];
    assign m0_rdata       = rdata_reg[0];
    assign m1_gnt         = gnt_reg[1];
    assign m1_err         = err_reg[1];
    assign m1_rvalid      = rvalid_reg[1];
    assign m1_rdata       = rdata_reg[1];
    assign mem_addr       = mem_addr_reg;
    assign mem_write_data = mem_wdata_reg;
    assign mem_memwrite   = memwrite_reg;
    assign mem_memread    = memread_reg;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: requests push descriptors, a
// negedge monitor checks grants/commands against a reference memory and
// checks read returns (data and latency) against per-port expectation queues.
module tb_data_memory_arbiter;

    localparam int unsigned WORDS = 16384;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        err    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread;

    logic [31:0] spram   [WORDS];
    logic [31:0] ref_mem [WORDS];
    req_t        pend_q  [2][$];
    exp_t        exp_q   [2][$];
    logic [31:0] prev_rdata [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    data_memory_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req         (req[0]),
        .m0_we          (we[0]),
        .m0_addr        (addr[0]),
        .m0_wdata       (wdata[0]),
        .m0_gnt         (gnt[0]),
        .m0_err         (err[0]),
        .m0_rvalid      (rvalid[0]),
        .m0_rdata       (rdata[0]),
        .m1_req         (req[1]),
        .m1_we          (we[1]),
        .m1_addr        (addr[1]),
        .m1_wdata       (wdata[1]),
        .m1_gnt         (gnt[1]),
        .m1_err         (err[1]),
        .m1_rvalid      (rvalid[1]),
        .m1_rdata       (rdata[1]),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPRAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_memwrite) spram[mem_addr[13:0]] <= mem_write_data;
        if (mem_memread)  mem_read_data <= spram[mem_addr[13:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Monitor: every granted command is judged against the held request and the
    // reference memory; reads schedule an expected return two cycles later.
    always @(negedge clk) begin
        req_t r;
        exp_t e;
        if (mon_en && !rst) begin
            check("one_gnt_per_cycle", {63'd0, gnt[0] & gnt[1]}, 64'd0);
            check("rd_wr_exclusive", {63'd0, mem_memread & mem_memwrite}, 64'd0);
            check("cmd_only_in_issue",
                  {63'd0, (mem_memread | mem_memwrite) & ~(gnt[0] | gnt[1])}, 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (gnt[p]) begin
                    if (pend_q[p].size() == 0) begin
                        fail($sformatf("p%0d_gnt_without_req", p));
                    end else begin
                        r = pend_q[p].pop_front();
                        if (r.addr < WORDS) begin
                            check($sformatf("p%0d_err", p), {63'd0, err[p]}, 64'd0);
                            check($sformatf("p%0d_memwrite", p), {63'd0, mem_memwrite}, {63'd0, r.we});
                            check($sformatf("p%0d_memread", p), {63'd0, mem_memread}, {63'd0, ~r.we});
                            check($sformatf("p%0d_mem_addr", p), {32'd0, mem_addr}, {32'd0, r.addr});
                            if (r.we) begin
                                check($sformatf("p%0d_mem_wdata", p), {32'd0, mem_write_data}, {32'd0, r.wdata});
                                ref_mem[r.addr[13:0]] = r.wdata;
                            end else begin
                                exp_q[p].push_back('{data: ref_mem[r.addr[13:0]], due: cyc + 2});
                            end
                        end else begin
                            check($sformatf("p%0d_err_oor", p), {63'd0, err[p]}, 64'd1);
                            check($sformatf("p%0d_no_cmd_oor", p),
                                  {63'd0, mem_memread | mem_memwrite}, 64'd0);
                        end
                    end
                end
                if (rvalid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        fail($sformatf("p%0d_unexpected_rvalid", p));
                    end else begin
                        e = exp_q[p].pop_front();
                        check($sformatf("p%0d_rdata", p), {32'd0, rdata[p]}, {32'd0, e.data});
                        check($sformatf("p%0d_rvalid_latency", p), 64'(cyc), 64'(e.due));
                    end
                end else begin
                    if (exp_q[p].size() > 0 && exp_q[p][0].due < cyc) begin
                        fail($sformatf("p%0d_rvalid_missing", p));
                        void'(exp_q[p].pop_front());
                    end
                    check($sformatf("p%0d_rdata_stable", p), {32'd0, rdata[p]}, {32'd0, prev_rdata[p]});
                end
            end
        end
        for (int p = 0; p < 2; p++) prev_rdata[p] = rdata[p];
    end

    task automatic set_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        pend_q[p].push_back('{we: w, addr: a, wdata: d});
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        req[p]   = 1'b1;
    endtask

    // Issue one request, hold it until granted, release it in the grant cycle.
    task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit got = 1'b0;
        set_req(p, w, a, d);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (gnt[p]) got = 1'b1;
        end
        req[p] = 1'b0;
        if (!got) begin
            fail($sformatf("p%0d_gnt_timeout", p));
            void'(pend_q[p].pop_back());
        end
        $display("txn port=%0d we=%0d addr=%08h wdata=%08h granted=%0d", p, w, a, d, got);
        @(posedge clk);
        #1;
    endtask

    task automatic driver(input int p, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            case ($urandom_range(0, 9))
                0:       a = 32'h0000_4000 + $urandom_range(0, 4095);
                1:       a = $urandom | 32'h0001_0000;
                2, 3, 4: a = $urandom_range(0, 15);
                default: a = $urandom_range(0, WORDS - 1);
            endcase
            do_req(p, 1'($urandom_range(0, 1)), a, $urandom);
        end
    endtask

    // Both ports request every IDLE; record the order of six grants.
    task automatic contention(output int ord [6]);
        int  n = 0;
        int  to = 0;
        bit  re [2];
        re[0] = 1'b0;
        re[1] = 1'b0;
        for (int p = 0; p < 2; p++) set_req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
        while (n < 6 && to < 300) begin
            @(negedge clk);
            to++;
            for (int p = 0; p < 2; p++) begin
                if (gnt[p] && n < 6) begin
                    ord[n] = p;
                    n++;
                    req[p] = 1'b0;
                    re[p]  = 1'b1;
                end
            end
            if (n < 6) begin
                @(posedge clk);
                #1;
                for (int p = 0; p < 2; p++) begin
                    if (re[p]) begin
                        set_req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
                        re[p] = 1'b0;
                    end
                end
            end
        end
        if (n < 6) fail("contention_timeout");
        req[0] = 1'b0;
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        pend_q[0].delete();
        pend_q[1].delete();
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctrl"}, {56'd0, gnt[0], gnt[1], err[0], err[1], rvalid[0], rvalid[1],
                                mem_memwrite, mem_memread}, 64'd0);
        check({name, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        check({name, "_mem_wdata"}, {32'd0, mem_write_data}, 64'd0);
        check({name, "_rdata"}, {rdata[0], rdata[1]}, 64'd0);
    endtask

    initial begin
        int ord [6];
        int exp_ord [6];
        for (int i = 0; i < int'(WORDS); i++) begin
            spram[i]   = 32'(i) * 32'h9E37_79B1 ^ 32'h0000_1234;
            ref_mem[i] = spram[i];
        end
        spram[16]   = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        for (int p = 0; p < 2; p++) begin
            req[p]   = 1'b0;
            we[p]    = 1'b0;
            addr[p]  = '0;
            wdata[p] = '0;
        end
        rst = 1'b1;
        #12;
        check_idle_outputs("reset");
        #10;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Contention straight after reset: last-grant pointer starts at the host.
        contention(ord);
        for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_HOST_PRIORITY_EN
            exp_ord[i] = 1;
`else
            exp_ord[i] = i % 2;
`endif
            $display("txn contention grant %0d -> port %0d", i, ord[i]);
            check($sformatf("contention_order_%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
        end
        repeat (4) @(posedge clk);
        #1;

        // Single read of a known word.
        do_req(0, 1'b0, 32'h0000_0010, 32'h0);
        // Host write then read at the top implemented word.
        do_req(1, 1'b1, 32'h0000_3FFF, 32'hA5A5_5A5A);
        do_req(1, 1'b0, 32'h0000_3FFF, 32'h0);
        // Out-of-range accesses, including one whose low bits alias word 0x10.
        do_req(0, 1'b0, 32'h0000_4000, 32'h0);
        do_req(0, 1'b0, 32'hFFFF_0010, 32'h0);
        do_req(1, 1'b1, 32'h0001_0000, 32'h1111_2222);
        do_req(0, 1'b0, 32'h0000_0000, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        // Randomised traffic from both ports at once.
        fork
            driver(0, 40);
            driver(1, 40);
        join
        repeat (6) @(posedge clk);
        #1;
        check("drain_p0", 64'(exp_q[0].size()), 64'd0);
        check("drain_p1", 64'(exp_q[1].size()), 64'd0);

        // Reset landing in the data-return cycle of a read.
        set_req(0, 1'b0, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 50 && !gnt[0]; i++) @(negedge clk);
        req[0] = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_read_reset");
        exp_q[0].delete();
        exp_q[1].delete();
        pend_q[0].delete();
        pend_q[1].delete();
        $display("txn reset asserted during read return");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(0, 1'b0, 32'h0000_0020, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_drain", 64'(exp_q[0].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
